rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 7 +
 rtl/rom_loader.sv | 77 +++++++
 tb/tb_rom_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared state encodings and stream-format constants for rom_loader
package rom_loader_pkg;
   localparam int INST_ADDR_W = 32;
   localparam int INST_DATA_W = 8;
   localparam int LEN_BYTES   = 4;
   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
endpackage

// File: rtl/rom_loader.sv
// rom_loader: loads a length-prefixed, checksummed byte stream into instruction memory
// clk/rst: clock, async active-high reset
// start_i: begin session (IDLE/DONE/ERR only); byte_i/byte_valid_i/byte_ready_o: stream handshake
// we_o/waddr_o/wdata_o: memory byte write port; hold_o: stall CPU fetch; done_o/err_o: session result
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int                     MEM_BYTES = 4096,
   parameter logic [INST_ADDR_W-1:0] BASE_ADDR = 32'h0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [7:0]             byte_i,
   input  logic                   byte_valid_i,
   output logic                   byte_ready_o,
   output logic                   we_o,
   output logic [INST_ADDR_W-1:0] waddr_o,
   output logic [INST_DATA_W-1:0] wdata_o,
   output logic                   hold_o,
   output logic                   done_o,
   output logic                   err_o
);
   state_t      state, state_nx;
   logic [31:0] cnt, len, n;
   logic [7:0]  sum;
   logic        acc, idle_like, last_len, last_data;
   assign byte_ready_o = state inside {LEN, DATA, CSUM};
   assign idle_like    = state inside {IDLE, DONE, ERR};
   assign acc          = byte_valid_i && byte_ready_o;
   // length arrives little-endian: shift each new byte in at the top
   assign n            = {byte_i, len[31:8]};
   assign last_len     = cnt == 32'(LEN_BYTES - 1);
   // 33-bit compare so the counter can never wrap past the length
   assign last_data    = {1'b0, cnt} + 33'd1 == {1'b0, len};
   assign hold_o       = state != DONE;
   assign done_o       = state == DONE;
   assign err_o        = state == ERR;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE, ERR: state_nx = start_i ? LEN : state;
         LEN:  if (acc && last_len) state_nx = n == 32'd0 ? CSUM : n > 32'(MEM_BYTES) ? ERR : DATA;
         DATA: if (acc && last_data) state_nx = CSUM;
         CSUM: if (acc) state_nx = byte_i == sum ? DONE : ERR;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt     <= '0;
         len     <= '0;
         sum     <= '0;
         we_o    <= 1'b0;
         waddr_o <= '0;
         wdata_o <= '0;
      end else begin
         we_o <= 1'b0;
         if (start_i && idle_like) begin
            cnt <= '0;
            len <= '0;
            sum <= '0;
         end else if (acc && state == LEN) begin
            len <= n;
            cnt <= last_len ? 32'd0 : cnt + 32'd1;
         end else if (acc && state == DATA) begin
            we_o    <= 1'b1;
            waddr_o <= BASE_ADDR + cnt;
            wdata_o <= byte_i;
            sum     <= sum + byte_i;
            cnt     <= cnt + 32'd1;
         end
      end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: table-driven and directed checks for rom_loader
module tb_rom_loader;
   localparam logic [31:0] BASE = 32'h100;
   logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, byte_valid_i = 1'b0;
   logic [7:0]  byte_i = 8'h0;
   logic        byte_ready_o, we_o, hold_o, done_o, err_o;
   logic [31:0] waddr_o;
   logic [7:0]  wdata_o;
   int          errors = 0, checks = 0;
   logic [31:0] wa_q[$];
   logic [7:0]  wd_q[$];
   typedef struct {
      logic [31:0] n;
      logic [63:0] d;
      logic [7:0]  cs;
      logic        ovr;
      logic        ed;
      logic        ee;
   } vec_t;
   vec_t vecs[9];
   rom_loader #(.MEM_BYTES(4096), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
      .byte_ready_o(byte_ready_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
      .hold_o(hold_o), .done_o(done_o), .err_o(err_o)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (we_o) begin
      wa_q.push_back(waddr_o);
      wd_q.push_back(wdata_o);
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic pulse_start;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask
   task automatic send(input logic [7:0] b);
      int t = 0;
      byte_i = b;
      byte_valid_i = 1'b1;
      while (!byte_ready_o && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!byte_ready_o) check("send_timeout", 32'd0, 32'd1);
      @(negedge clk);
      byte_valid_i = 1'b0;
   endtask
   task automatic send_len(input logic [31:0] n);
      for (int i = 0; i < 4; i++) send(n[8*i +: 8]);
   endtask
   task automatic check_writes(input string name, input int cnt, input logic [63:0] d);
      check({name, "_wcount"}, wa_q.size(), cnt);
      for (int k = 0; k < cnt && k < wa_q.size(); k++) begin
         check({name, "_waddr"}, wa_q[k], BASE + k);
         check({name, "_wdata"}, wd_q[k], d[8*k +: 8]);
      end
   endtask
   initial begin
      logic [63:0] d;
      logic [7:0]  s;
      vecs[0] = '{32'd4,       64'h13,                 8'h13, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{32'd4,       64'h13,                 8'h14, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{32'h1001,    64'h0,                  8'h00, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{32'd0,       64'h0,                  8'h00, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{32'd0,       64'h0,                  8'h01, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{32'd3,       64'h1002FF,             8'h11, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{32'd8,       64'h0807060504030201,   8'h24, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{32'h10000,   64'h0,                  8'h00, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{32'd1,       64'hAA,                 8'hAB, 1'b0, 1'b0, 1'b1};
      #1;
      check("rst_ready", byte_ready_o, 0);
      check("rst_we", we_o, 0);
      check("rst_waddr", waddr_o, 0);
      check("rst_wdata", wdata_o, 0);
      check("rst_hold", hold_o, 1);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      @(negedge clk);
      rst = 1'b0;
      byte_valid_i = 1'b1;
      byte_i = 8'h55;
      repeat (3) @(negedge clk);
      check("idle_no_consume_ready", byte_ready_o, 0);
      check("idle_no_write", wa_q.size(), 0);
      byte_valid_i = 1'b0;
      foreach (vecs[v]) begin
         wa_q.delete();
         wd_q.delete();
         pulse_start();
         check("vec_ready_len", byte_ready_o, 1);
         check("vec_done_cleared", done_o, 0);
         check("vec_err_cleared", err_o, 0);
         send_len(vecs[v].n);
         if (!vecs[v].ovr) begin
            for (int k = 0; k < vecs[v].n; k++) send(vecs[v].d[8*k +: 8]);
            send(vecs[v].cs);
         end
         repeat (2) @(negedge clk);
         check("vec_done", done_o, vecs[v].ed);
         check("vec_err", err_o, vecs[v].ee);
         check("vec_hold", hold_o, !vecs[v].ed);
         check("vec_ready_end", byte_ready_o, 0);
         check_writes("vec", vecs[v].ovr ? 0 : int'(vecs[v].n), vecs[v].d);
      end
      wa_q.delete();
      wd_q.delete();
      d = 64'h8877665544332211;
      s = 8'h0;
      for (int k = 0; k < 8; k++) s += d[8*k +: 8];
      pulse_start();
      send_len(32'd8);
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if (k == 3) start_i = 1'b1;
         send(d[8*k +: 8]);
         start_i = 1'b0;
      end
      send(s);
      repeat (2) @(negedge clk);
      check("rand_done", done_o, 1);
      check_writes("rand", 8, d);
      wa_q.delete();
      wd_q.delete();
      pulse_start();
      send_len(32'd8);
      send(8'hA1);
      send(8'hB2);
      #2 rst = 1'b1;
      #1;
      check("midrst_we", we_o, 0);
      check("midrst_ready", byte_ready_o, 0);
      check("midrst_waddr", waddr_o, 0);
      check("midrst_hold", hold_o, 1);
      check("midrst_err", err_o, 0);
      @(negedge clk);
      rst = 1'b0;
      byte_valid_i = 1'b1;
      repeat (4) @(negedge clk);
      byte_valid_i = 1'b0;
      check_writes("midrst", 2, 64'hB2A1);
      wa_q.delete();
      wd_q.delete();
      pulse_start();
      send_len(32'd4);
      send(8'h13);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      send(8'h13);
      repeat (2) @(negedge clk);
      check("restart_done", done_o, 1);
      check("restart_hold", hold_o, 0);
      check_writes("restart", 4, 64'h13);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
